id_pipe: RTL and testbench
==========================

# id_pipe

Parametrised decode stage for the MIPS integer pipeline, placed between the IF/ID register and EX. It decodes the logic and shift subset, fetches operands through the regfile read ports, and forwards results from `N_FWD` downstream stages. Unlike the combinational decoder, it detects load-use hazards and stalls on them. Its output is a registered ID/EX slot with a valid/ready handshake and a flush input.

## Interface
- `DATA_W`, 32, operand and result width
- `RADDR_W`, 5, register address width
- `N_FWD`, 2, number of forwarding sources; index 0 is the youngest (EX) and has the highest priority
- `CNT_W`, 16, width of the stall counter

- `clk`  in  1  clock
- `rst_n`  in  1  reset, synchronous, active-low; one clock domain only
- `flush_i`  in  1  kill the ID/EX slot and refuse input this cycle
- `in_valid_i`  in  1  an instruction is presented
- `in_ready_o`  out  1  the instruction is accepted this cycle
- `pc_i`, `inst_i`  in  32 each  instruction address and instruction word
- `re1_o`, `re2_o`  out  1  regfile read enables
- `raddr1_o`, `raddr2_o`  out  RADDR_W  regfile read addresses
- `rdata1_i`, `rdata2_i`  in  DATA_W  regfile read data
- `fwd_we_i`  in  N_FWD  per-source write enable
- `fwd_pend_i`  in  N_FWD  per-source flag: result not yet available (load in flight)
- `fwd_waddr_i`  in  N_FWD*RADDR_W  packed destination addresses; source i is in slice [i*RADDR_W +: RADDR_W]
- `fwd_wdata_i`  in  N_FWD*DATA_W  packed result data
- `out_valid_o`  out  1  the ID/EX slot holds an instruction
- `out_ready_i`  in  1  EX consumes the slot
- `pc_o`  out  32  registered PC
- `we_o`, `waddr_o`  out  1, RADDR_W  registered writeback control
- `aluop_o`, `alusel_o`  out  AluOpBus, AluSelBus  registered ALU control
- `data1_o`, `data2_o`  out  DATA_W  registered operands
- `illegal_o`  out  1  registered: the slot holds an undecodable instruction
- `stall_cnt_o`  out  CNT_W  saturating count of hazard-stall cycles

## Operation
- **Decode (combinational):** from `inst_i`, covering and/or/xor/nor, sllv/srlv/srav (sa=0), sll/srl/sra (`inst_i[31:21]`=0), ori/andi/xori (zero-extended immediate), lui (immediate in bits [31:16], OR with rs), sync and pref (NOP, `we`=0, no reads). Encodings use the `EXE_*` macros in define.vh.
- **Read enables:** `re1_o`/`re2_o` are forced to 0 when `in_valid_i`=0. Addresses are rs and rt.
- **Shift operands:** for sll/srl/sra, data1 = {zeros, sa} and data2 = rt. Immediates take the operand slot whose read enable is 0. An unread, non-immediate operand is 0.
- **Forwarding:** applies per enabled port with raddr≠0. Scan i = 0..N_FWD-1; the first i with `fwd_we_i[i]` and a matching address wins. If the winner has `fwd_pend_i[i]`=1, that port has a hazard. Otherwise its data is used. With no match, the regfile data is used. Address 0 always yields 0 and never hazards.
- **Hazard:** asserted when either port has a hazard and `in_valid_i`=1.
- **Input handshake:** `in_ready_o` = !flush_i & !hazard & (!out_valid_o | out_ready_i). The instruction is captured when `in_valid_i` & `in_ready_o`.
- **Slot update, per clock edge, in priority order:**
  - reset: clear all
  - `flush_i`: `out_valid_o` = 0
  - capture: load all outputs and set `out_valid_o` = 1
  - `out_ready_i`: `out_valid_o` = 0
  - otherwise: hold
- **Illegal instruction:** captured with `illegal_o`=1, `we_o`=0, NOP/RES_NOP, and both data outputs 0.
- **Stall counter:** `stall_cnt_o` increments on each cycle with hazard & !flush_i, and saturates at all-ones.

## Timing
- Latency is 1 cycle from capture to `out_valid_o`. Full throughput: back-to-back capture is allowed when `out_ready_i`=1.
- Forwarding and hazard detection are combinational in the same cycle as `inst_i`. The forwarded value is sampled at the capture edge.
- Reset: `out_valid_o`, `we_o`, `illegal_o` = 0; `pc_o`, `waddr_o`, `data*_o` = 0; `aluop_o` = EXE_NOP_OP; `alusel_o` = EXE_RES_NOP; `stall_cnt_o` = 0. Reset asserted mid-stall drops the slot and clears the counter.
- A stalled instruction must be held stable by the upstream stage. Once `fwd_pend_i` falls, capture occurs in the same cycle.
- When flush and capture conditions coincide, flush wins and no capture occurs (`in_ready_o`=0).
- When the slot is full and `out_ready_i`=0, outputs hold and `in_ready_o`=0.

## Test plan
- **Basic ori:** reset, then ori $1,$0,0x1234 → after 1 cycle `out_valid_o`=1, `data1_o`=0, `data2_o`=0x00001234, `waddr_o`=1, `we_o`=1.
- **Forward priority:** and $3,$1,$2 with fwd0={we=1, addr=1, data=0xA}, fwd1={we=1, addr=1, data=0xB}, regfile=0xC → `data1_o`=0xA.
- **Load-use stall:** fwd0 {addr=2, pend=1} for 3 cycles with or $4,$2,$2 → `in_ready_o`=0 for 3 cycles, `stall_cnt_o`=3. Capture happens when pend drops.
- **Back-pressure:** `out_ready_i`=0 for 2 cycles → outputs stable, `in_ready_o`=0. Release gives back-to-back captures.
- **Flush during stall:** `flush_i` asserted with a full slot and a pending hazard → `out_valid_o`=0 next cycle, counter unchanged that cycle.
- **Edge cases:** illegal opcode 0x3F → `illegal_o`=1, `we_o`=0. Register $0 with fwd {addr=0, pend=1} → no stall, operand 0. sll $5,$6,7 → `data1_o`=7.

Source files
------------

// File: rtl/id_pipe_if.sv
// Shared decode encodings plus the handshake/bus interface of the id_pipe
// decode stage.
//   master : upstream/environment side (drives instruction, regfile data,
//            forwarding sources, flush and EX ready)
//   slave  : id_pipe side (drives in_ready, regfile read ports, ID/EX slot)
package id_pipe_pkg;

  localparam int unsigned ALUOP_W  = 8;
  localparam int unsigned ALUSEL_W = 3;

  typedef logic [ALUOP_W-1:0]  alu_op_t;
  typedef logic [ALUSEL_W-1:0] alu_sel_t;

  // Primary opcodes
  localparam logic [5:0] EXE_SPECIAL_INST = 6'b000000;
  localparam logic [5:0] EXE_ANDI         = 6'b001100;
  localparam logic [5:0] EXE_ORI          = 6'b001101;
  localparam logic [5:0] EXE_XORI         = 6'b001110;
  localparam logic [5:0] EXE_LUI          = 6'b001111;
  localparam logic [5:0] EXE_PREF         = 6'b110011;

  // SPECIAL function codes
  localparam logic [5:0] EXE_AND  = 6'b100100;
  localparam logic [5:0] EXE_OR   = 6'b100101;
  localparam logic [5:0] EXE_XOR  = 6'b100110;
  localparam logic [5:0] EXE_NOR  = 6'b100111;
  localparam logic [5:0] EXE_SLL  = 6'b000000;
  localparam logic [5:0] EXE_SRL  = 6'b000010;
  localparam logic [5:0] EXE_SRA  = 6'b000011;
  localparam logic [5:0] EXE_SLLV = 6'b000100;
  localparam logic [5:0] EXE_SRLV = 6'b000110;
  localparam logic [5:0] EXE_SRAV = 6'b000111;
  localparam logic [5:0] EXE_SYNC = 6'b001111;

  // ALU operations
  localparam alu_op_t EXE_NOP_OP = 8'b00000000;
  localparam alu_op_t EXE_AND_OP = 8'b00100100;
  localparam alu_op_t EXE_OR_OP  = 8'b00100101;
  localparam alu_op_t EXE_XOR_OP = 8'b00100110;
  localparam alu_op_t EXE_NOR_OP = 8'b00100111;
  localparam alu_op_t EXE_SLL_OP = 8'b01111100;
  localparam alu_op_t EXE_SRL_OP = 8'b00000010;
  localparam alu_op_t EXE_SRA_OP = 8'b00000011;

  // Result selectors
  localparam alu_sel_t EXE_RES_NOP   = 3'b000;
  localparam alu_sel_t EXE_RES_LOGIC = 3'b001;
  localparam alu_sel_t EXE_RES_SHIFT = 3'b010;

endpackage

interface id_pipe_if #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned RADDR_W = 5,
  parameter int unsigned N_FWD   = 2,
  parameter int unsigned CNT_W   = 16
) ();

  logic                        flush_i;
  logic                        in_valid_i;
  logic                        in_ready_o;
  logic [31:0]                 pc_i;
  logic [31:0]                 inst_i;
  logic                        re1_o;
  logic                        re2_o;
  logic [RADDR_W-1:0]          raddr1_o;
  logic [RADDR_W-1:0]          raddr2_o;
  logic [DATA_W-1:0]           rdata1_i;
  logic [DATA_W-1:0]           rdata2_i;
  logic [N_FWD-1:0]            fwd_we_i;
  logic [N_FWD-1:0]            fwd_pend_i;
  logic [N_FWD*RADDR_W-1:0]    fwd_waddr_i;
  logic [N_FWD*DATA_W-1:0]     fwd_wdata_i;
  logic                        out_valid_o;
  logic                        out_ready_i;
  logic [31:0]                 pc_o;
  logic                        we_o;
  logic [RADDR_W-1:0]          waddr_o;
  id_pipe_pkg::alu_op_t        aluop_o;
  id_pipe_pkg::alu_sel_t       alusel_o;
  logic [DATA_W-1:0]           data1_o;
  logic [DATA_W-1:0]           data2_o;
  logic                        illegal_o;
  logic [CNT_W-1:0]            stall_cnt_o;

  modport master (
    output flush_i, in_valid_i, pc_i, inst_i, rdata1_i, rdata2_i,
           fwd_we_i, fwd_pend_i, fwd_waddr_i, fwd_wdata_i, out_ready_i,
    input  in_ready_o, re1_o, re2_o, raddr1_o, raddr2_o, out_valid_o,
           pc_o, we_o, waddr_o, aluop_o, alusel_o, data1_o, data2_o,
           illegal_o, stall_cnt_o
  );

  modport slave (
    input  flush_i, in_valid_i, pc_i, inst_i, rdata1_i, rdata2_i,
           fwd_we_i, fwd_pend_i, fwd_waddr_i, fwd_wdata_i, out_ready_i,
    output in_ready_o, re1_o, re2_o, raddr1_o, raddr2_o, out_valid_o,
           pc_o, we_o, waddr_o, aluop_o, alusel_o, data1_o, data2_o,
           illegal_o, stall_cnt_o
  );

endinterface

// File: rtl/id_pipe.sv
// MIPS decode stage for the logic/shift subset with operand forwarding,
// load-use stall detection and a registered ID/EX slot (valid/ready + flush).
// Ports:
//   clk    : clock
//   rst_n  : synchronous active-low reset
//   bus    : id_pipe_if.slave -- instruction in, regfile read ports,
//            forwarding sources, ID/EX slot out, stall counter
module id_pipe
  import id_pipe_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned RADDR_W = 5,
  parameter int unsigned N_FWD   = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  id_pipe_if.slave bus
);

  // Instruction fields
  logic [5:0]         op;
  logic [5:0]         fn;
  logic [4:0]         sa;
  logic [RADDR_W-1:0] rs;
  logic [RADDR_W-1:0] rt;
  logic [RADDR_W-1:0] rd;

  assign op = bus.inst_i[31:26];
  assign fn = bus.inst_i[5:0];
  assign sa = bus.inst_i[10:6];
  assign rs = RADDR_W'(bus.inst_i[25:21]);
  assign rt = RADDR_W'(bus.inst_i[20:16]);
  assign rd = RADDR_W'(bus.inst_i[15:11]);

  // Decoded controls
  logic               dec_re1;
  logic               dec_re2;
  logic               dec_we;
  logic [RADDR_W-1:0] dec_waddr;
  alu_op_t            dec_aluop;
  alu_sel_t           dec_alusel;
  logic               dec_illegal;
  logic [DATA_W-1:0]  dec_imm;
  logic               imm_on1;
  logic               imm_on2;

  // Combinational decode; anything not listed is flagged illegal
  always_comb begin
    dec_re1     = 1'b0;
    dec_re2     = 1'b0;
    dec_we      = 1'b0;
    dec_waddr   = '0;
    dec_aluop   = EXE_NOP_OP;
    dec_alusel  = EXE_RES_NOP;
    dec_illegal = 1'b0;
    dec_imm     = '0;
    imm_on1     = 1'b0;
    imm_on2     = 1'b0;
    if (bus.inst_i[31:21] == 11'd0 &&
        (fn == EXE_SLL || fn == EXE_SRL || fn == EXE_SRA)) begin
      // Constant shifts: shift amount rides in operand 1
      dec_re2    = 1'b1;
      imm_on1    = 1'b1;
      dec_imm    = DATA_W'(sa);
      dec_we     = 1'b1;
      dec_waddr  = rd;
      dec_alusel = EXE_RES_SHIFT;
      case (fn)
        EXE_SLL: dec_aluop = EXE_SLL_OP;
        EXE_SRL: dec_aluop = EXE_SRL_OP;
        default: dec_aluop = EXE_SRA_OP;
      endcase
    end else if (op == EXE_SPECIAL_INST) begin
      case (fn)
        EXE_AND, EXE_OR, EXE_XOR, EXE_NOR: begin
          dec_re1    = 1'b1;
          dec_re2    = 1'b1;
          dec_we     = 1'b1;
          dec_waddr  = rd;
          dec_alusel = EXE_RES_LOGIC;
          case (fn)
            EXE_AND: dec_aluop = EXE_AND_OP;
            EXE_OR:  dec_aluop = EXE_OR_OP;
            EXE_XOR: dec_aluop = EXE_XOR_OP;
            default: dec_aluop = EXE_NOR_OP;
          endcase
        end
        EXE_SLLV, EXE_SRLV, EXE_SRAV: begin
          if (sa == 5'd0) begin
            dec_re1    = 1'b1;
            dec_re2    = 1'b1;
            dec_we     = 1'b1;
            dec_waddr  = rd;
            dec_alusel = EXE_RES_SHIFT;
            case (fn)
              EXE_SLLV: dec_aluop = EXE_SLL_OP;
              EXE_SRLV: dec_aluop = EXE_SRL_OP;
              default:  dec_aluop = EXE_SRA_OP;
            endcase
          end else begin
            dec_illegal = 1'b1;
          end
        end
        EXE_SYNC: ;
        default: dec_illegal = 1'b1;
      endcase
    end else begin
      case (op)
        EXE_ANDI, EXE_ORI, EXE_XORI, EXE_LUI: begin
          // Immediate rides in operand 2; lui is an OR of rs with imm<<16
          dec_re1    = 1'b1;
          imm_on2    = 1'b1;
          dec_we     = 1'b1;
          dec_waddr  = rt;
          dec_alusel = EXE_RES_LOGIC;
          if (op == EXE_LUI) dec_imm = DATA_W'({bus.inst_i[15:0], 16'h0000});
          else               dec_imm = DATA_W'(bus.inst_i[15:0]);
          case (op)
            EXE_ANDI: dec_aluop = EXE_AND_OP;
            EXE_XORI: dec_aluop = EXE_XOR_OP;
            default:  dec_aluop = EXE_OR_OP;
          endcase
        end
        EXE_PREF: ;
        default: dec_illegal = 1'b1;
      endcase
    end
  end

  // Regfile read ports
  logic re1;
  logic re2;

  assign re1          = bus.in_valid_i & dec_re1;
  assign re2          = bus.in_valid_i & dec_re2;
  assign bus.re1_o    = re1;
  assign bus.re2_o    = re2;
  assign bus.raddr1_o = rs;
  assign bus.raddr2_o = rt;

  // Per-port forwarding; the lowest-index matching source wins
  logic               port_re   [2];
  logic [RADDR_W-1:0] port_addr [2];
  logic [DATA_W-1:0]  port_rf   [2];
  logic [DATA_W-1:0]  port_val  [2];
  logic               port_haz  [2];

  assign port_re[0]   = re1;
  assign port_re[1]   = re2;
  assign port_addr[0] = rs;
  assign port_addr[1] = rt;
  assign port_rf[0]   = bus.rdata1_i;
  assign port_rf[1]   = bus.rdata2_i;

  always_comb begin
    logic matched;
    for (int p = 0; p < 2; p++) begin
      port_val[p] = '0;
      port_haz[p] = 1'b0;
      matched     = 1'b0;
      if (port_re[p] && port_addr[p] != '0) begin
        port_val[p] = port_rf[p];
        for (int i = 0; i < int'(N_FWD); i++) begin
          if (!matched && bus.fwd_we_i[i] &&
              bus.fwd_waddr_i[i*RADDR_W +: RADDR_W] == port_addr[p]) begin
            matched     = 1'b1;
            port_haz[p] = bus.fwd_pend_i[i];
            port_val[p] = bus.fwd_wdata_i[i*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  // Operand muxing: immediates occupy the unread slot, unread slots are 0
  logic [DATA_W-1:0] op1;
  logic [DATA_W-1:0] op2;

  assign op1 = imm_on1 ? dec_imm : port_val[0];
  assign op2 = imm_on2 ? dec_imm : port_val[1];

  // Handshake
  logic hazard;
  logic ready;
  logic capture;
  logic out_valid;

  assign hazard         = bus.in_valid_i & (port_haz[0] | port_haz[1]);
  assign ready          = ~bus.flush_i & ~hazard & (~out_valid | bus.out_ready_i);
  assign capture        = bus.in_valid_i & ready;
  assign bus.in_ready_o = ready;

  // ID/EX slot registers
  logic [31:0]        pc_q;
  logic               we_q;
  logic [RADDR_W-1:0] waddr_q;
  alu_op_t            aluop_q;
  alu_sel_t           alusel_q;
  logic [DATA_W-1:0]  data1_q;
  logic [DATA_W-1:0]  data2_q;
  logic               illegal_q;
  logic [CNT_W-1:0]   stall_cnt;

  // Slot update: flush beats capture, capture beats drain
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      pc_q      <= '0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      aluop_q   <= EXE_NOP_OP;
      alusel_q  <= EXE_RES_NOP;
      data1_q   <= '0;
      data2_q   <= '0;
      illegal_q <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (bus.flush_i) begin
        out_valid <= 1'b0;
      end else if (capture) begin
        out_valid <= 1'b1;
        pc_q      <= bus.pc_i;
        we_q      <= dec_we;
        waddr_q   <= dec_waddr;
        aluop_q   <= dec_aluop;
        alusel_q  <= dec_alusel;
        data1_q   <= op1;
        data2_q   <= op2;
        illegal_q <= dec_illegal;
      end else if (bus.out_ready_i) begin
        out_valid <= 1'b0;
      end
      // Saturating count of hazard-stall cycles
      if (hazard && !bus.flush_i && stall_cnt != {CNT_W{1'b1}}) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.out_valid_o = out_valid;
  assign bus.pc_o        = pc_q;
  assign bus.we_o        = we_q;
  assign bus.waddr_o     = waddr_q;
  assign bus.aluop_o     = aluop_q;
  assign bus.alusel_o    = alusel_q;
  assign bus.data1_o     = data1_q;
  assign bus.data2_o     = data2_q;
  assign bus.illegal_o   = illegal_q;
  assign bus.stall_cnt_o = stall_cnt;

endmodule

// File: tb/tb_id_pipe.sv
// Self-checking bench for id_pipe: directed scenarios plus a randomized run
// against a behavioural decode/slot model.
module tb_id_pipe;
  import id_pipe_pkg::*;

  localparam int unsigned CW = 4;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  id_pipe_if #(.DATA_W(32), .RADDR_W(5), .N_FWD(2), .CNT_W(CW)) bus ();

  id_pipe #(.DATA_W(32), .RADDR_W(5), .N_FWD(2), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Environment: regfile and forwarding sources
  logic [31:0] regs     [32];
  logic [1:0]  fwd_we;
  logic [1:0]  fwd_pend;
  logic [4:0]  fwd_addr [2];
  logic [31:0] fwd_data [2];

  assign bus.rdata1_i    = regs[bus.raddr1_o];
  assign bus.rdata2_i    = regs[bus.raddr2_o];
  assign bus.fwd_we_i    = fwd_we;
  assign bus.fwd_pend_i  = fwd_pend;
  assign bus.fwd_waddr_i = {fwd_addr[1], fwd_addr[0]};
  assign bus.fwd_wdata_i = {fwd_data[1], fwd_data[0]};

  typedef struct packed {
    logic        rd1;
    logic        rd2;
    logic        haz;
    logic        we;
    logic [4:0]  wa;
    logic [7:0]  aop;
    logic [2:0]  sel;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        ill;
  } exp_t;

  function automatic logic [31:0] r_inst(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sa,
                                         input logic [5:0] fn);
    return {6'd0, rs, rt, rd, sa, fn};
  endfunction

  function automatic logic [31:0] i_inst(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Value seen for a register read: {pending, data}
  function automatic logic [32:0] opnd(input logic [4:0] a);
    if (a == 5'd0) return 33'd0;
    for (int i = 0; i < 2; i++)
      if (fwd_we[i] && fwd_addr[i] == a) return {fwd_pend[i], fwd_data[i]};
    return {1'b0, regs[a]};
  endfunction

  // Reference decode from the instruction-set rules
  function automatic exp_t model(input logic [31:0] w);
    exp_t        e;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  sa;
    logic        immsh;
    logic        immlo;
    logic [31:0] imm;
    logic [32:0] o1;
    logic [32:0] o2;
    op = w[31:26]; fn = w[5:0]; sa = w[10:6];
    e = '0; immsh = 1'b0; immlo = 1'b0; imm = 32'd0;
    if (w[31:21] == 11'd0 && fn inside {6'h00, 6'h02, 6'h03}) begin
      e.rd2 = 1'b1; immsh = 1'b1; e.we = 1'b1; e.wa = w[15:11]; e.sel = EXE_RES_SHIFT;
      e.aop = (fn == 6'h00) ? EXE_SLL_OP : (fn == 6'h02) ? EXE_SRL_OP : EXE_SRA_OP;
    end else if (op == 6'h00) begin
      if (fn inside {6'h24, 6'h25, 6'h26, 6'h27}) begin
        e.rd1 = 1'b1; e.rd2 = 1'b1; e.we = 1'b1; e.wa = w[15:11]; e.sel = EXE_RES_LOGIC;
        e.aop = (fn == 6'h24) ? EXE_AND_OP : (fn == 6'h25) ? EXE_OR_OP :
                (fn == 6'h26) ? EXE_XOR_OP : EXE_NOR_OP;
      end else if (fn inside {6'h04, 6'h06, 6'h07} && sa == 5'd0) begin
        e.rd1 = 1'b1; e.rd2 = 1'b1; e.we = 1'b1; e.wa = w[15:11]; e.sel = EXE_RES_SHIFT;
        e.aop = (fn == 6'h04) ? EXE_SLL_OP : (fn == 6'h06) ? EXE_SRL_OP : EXE_SRA_OP;
      end else if (fn != 6'h0F) begin
        e.ill = 1'b1;
      end
    end else if (op inside {6'h0C, 6'h0D, 6'h0E, 6'h0F}) begin
      e.rd1 = 1'b1; immlo = 1'b1; e.we = 1'b1; e.wa = w[20:16]; e.sel = EXE_RES_LOGIC;
      e.aop = (op == 6'h0C) ? EXE_AND_OP : (op == 6'h0E) ? EXE_XOR_OP : EXE_OR_OP;
      imm = (op == 6'h0F) ? {w[15:0], 16'h0} : {16'h0, w[15:0]};
    end else if (op != 6'h33) begin
      e.ill = 1'b1;
    end
    o1 = opnd(w[25:21]);
    o2 = opnd(w[20:16]);
    e.d1  = e.rd1 ? o1[31:0] : (immsh ? {27'd0, sa} : 32'd0);
    e.d2  = e.rd2 ? o2[31:0] : (immlo ? imm : 32'd0);
    e.haz = (e.rd1 & o1[32]) | (e.rd2 & o2[32]);
    return e;
  endfunction

  function automatic logic [31:0] gen_inst();
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sa;
    logic [15:0] imm;
    logic [5:0]  lfn [4];
    logic [5:0]  vfn [3];
    logic [5:0]  ifn [3];
    logic [5:0]  iop [4];
    int k;
    lfn = '{6'h24, 6'h25, 6'h26, 6'h27};
    vfn = '{6'h04, 6'h06, 6'h07};
    ifn = '{6'h00, 6'h02, 6'h03};
    iop = '{6'h0C, 6'h0D, 6'h0E, 6'h0F};
    rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7));
    rd = 5'($urandom_range(0, 7)); sa = 5'($urandom);
    imm = 16'($urandom);
    k = $urandom_range(0, 16);
    if (k < 4)       return r_inst(rs, rt, rd, 5'd0, lfn[k]);
    else if (k < 7)  return r_inst(rs, rt, rd, ($urandom_range(0, 3) == 0) ? sa : 5'd0, vfn[k-4]);
    else if (k < 10) return r_inst(5'd0, rt, rd, sa, ifn[k-7]);
    else if (k < 14) return i_inst(iop[k-10], rs, rt, imm);
    else if (k == 14) return 32'h0000_000F;
    else if (k == 15) return {6'h33, 26'($urandom)};
    else              return $urandom;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_fwd();
    fwd_we = 2'b00; fwd_pend = 2'b00;
    fwd_addr[0] = 5'd0; fwd_addr[1] = 5'd0;
    fwd_data[0] = 32'd0; fwd_data[1] = 32'd0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.flush_i = 1'b0; bus.in_valid_i = 1'b0; bus.out_ready_i = 1'b1;
    clear_fwd();
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    bus.in_valid_i = 1'b1; bus.pc_i = 32'h100;
    bus.inst_i = i_inst(6'h0D, 5'd0, 5'd1, 16'h1234);
    tick();
    bus.in_valid_i = 1'b0; bus.out_ready_i = 1'b0;
    rst_n = 1'b0;
    tick();
    if (bus.out_valid_o !== 1'b0) begin
      bad++; $display("FAIL reset_valid got=%0b exp=0", bus.out_valid_o);
    end
    total++;
    if (bus.stall_cnt_o !== 4'd0) begin
      bad++; $display("FAIL reset_cnt got=%0d exp=0", bus.stall_cnt_o);
    end
    total++;
    if ({bus.we_o, bus.illegal_o, bus.pc_o, bus.waddr_o, bus.data1_o, bus.data2_o,
         bus.aluop_o, bus.alusel_o} !== {2'b00, 32'd0, 5'd0, 64'd0, EXE_NOP_OP, EXE_RES_NOP}) begin
      bad++; $display("FAIL reset_slot got pc=%h we=%b d1=%h d2=%h aop=%h exp all zero/NOP",
                      bus.pc_o, bus.we_o, bus.data1_o, bus.data2_o, bus.aluop_o);
    end
    total++;
    rst_n = 1'b1; bus.out_ready_i = 1'b1;
  endtask

  task automatic test_ori();
    bus.in_valid_i = 1'b1; bus.pc_i = 32'h400;
    bus.inst_i = i_inst(6'h0D, 5'd0, 5'd1, 16'h1234);
    #1;
    if (bus.in_ready_o !== 1'b1) begin
      bad++; $display("FAIL ori_ready got=%0b exp=1", bus.in_ready_o);
    end
    total++;
    tick();
    if ({bus.out_valid_o, bus.we_o, bus.waddr_o, bus.data1_o, bus.data2_o, bus.aluop_o,
         bus.alusel_o, bus.pc_o} !== {2'b11, 5'd1, 32'd0, 32'h1234, EXE_OR_OP, EXE_RES_LOGIC, 32'h400}) begin
      bad++; $display("FAIL ori_slot got v=%b we=%b wa=%0d d1=%h d2=%h aop=%h exp v=1 we=1 wa=1 d1=0 d2=1234 aop=%h",
                      bus.out_valid_o, bus.we_o, bus.waddr_o, bus.data1_o, bus.data2_o, bus.aluop_o, EXE_OR_OP);
    end
    total++;
    bus.in_valid_i = 1'b0;
    tick();
    if (bus.out_valid_o !== 1'b0) begin
      bad++; $display("FAIL ori_drain got=%0b exp=0", bus.out_valid_o);
    end
    total++;
  endtask

  task automatic test_fwd_priority();
    logic [31:0] exp_d1 [3];
    exp_d1 = '{32'hA, 32'hB, 32'hC};
    regs[1] = 32'hC; regs[2] = 32'h22;
    fwd_we = 2'b11; fwd_pend = 2'b00;
    fwd_addr[0] = 5'd1; fwd_data[0] = 32'hA;
    fwd_addr[1] = 5'd1; fwd_data[1] = 32'hB;
    bus.in_valid_i = 1'b1; bus.inst_i = r_inst(5'd1, 5'd2, 5'd3, 5'd0, 6'h24);
    for (int s = 0; s < 3; s++) begin
      tick();
      if ({bus.data1_o, bus.data2_o, bus.waddr_o} !== {exp_d1[s], 32'h22, 5'd3}) begin
        bad++; $display("FAIL fwd_prio_%0d got d1=%h d2=%h wa=%0d exp d1=%h d2=22 wa=3",
                        s, bus.data1_o, bus.data2_o, bus.waddr_o, exp_d1[s]);
      end
      total++;
      if (s == 0) fwd_we = 2'b10;
      else        fwd_we = 2'b00;
    end
    bus.in_valid_i = 1'b0; clear_fwd();
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    regs[2] = 32'h77;
    fwd_we = 2'b01; fwd_pend = 2'b01; fwd_addr[0] = 5'd2; fwd_data[0] = 32'h55;
    bus.in_valid_i = 1'b1; bus.pc_i = 32'h200; bus.inst_i = r_inst(5'd2, 5'd2, 5'd4, 5'd0, 6'h25);
    for (int s = 0; s < 3; s++) begin
      #1;
      if (bus.in_ready_o !== 1'b0) begin
        bad++; $display("FAIL lu_stall_ready_%0d got=%0b exp=0", s, bus.in_ready_o);
      end
      total++;
      tick();
    end
    if ({bus.stall_cnt_o, bus.out_valid_o} !== {4'd3, 1'b0}) begin
      bad++; $display("FAIL lu_cnt got cnt=%0d v=%b exp cnt=3 v=0", bus.stall_cnt_o, bus.out_valid_o);
    end
    total++;
    fwd_pend = 2'b00;
    #1;
    if (bus.in_ready_o !== 1'b1) begin
      bad++; $display("FAIL lu_release_ready got=%0b exp=1", bus.in_ready_o);
    end
    total++;
    tick();
    if ({bus.out_valid_o, bus.data1_o, bus.data2_o, bus.stall_cnt_o} !== {1'b1, 32'h55, 32'h55, 4'd3}) begin
      bad++; $display("FAIL lu_capture got v=%b d1=%h d2=%h cnt=%0d exp v=1 d1=55 d2=55 cnt=3",
                      bus.out_valid_o, bus.data1_o, bus.data2_o, bus.stall_cnt_o);
    end
    total++;
    bus.in_valid_i = 1'b0; clear_fwd();
    tick();
  endtask

  task automatic test_back_to_back();
    bus.out_ready_i = 1'b1; bus.in_valid_i = 1'b1;
    bus.pc_i = 32'h10; bus.inst_i = i_inst(6'h0D, 5'd0, 5'd1, 16'h1111);
    tick();
    bus.out_ready_i = 1'b0;
    bus.pc_i = 32'h14; bus.inst_i = i_inst(6'h0E, 5'd0, 5'd2, 16'h2222);
    for (int s = 0; s < 2; s++) begin
      #1;
      if (bus.in_ready_o !== 1'b0) begin
        bad++; $display("FAIL bp_ready_%0d got=%0b exp=0", s, bus.in_ready_o);
      end
      total++;
      tick();
      if ({bus.out_valid_o, bus.pc_o, bus.data2_o, bus.waddr_o} !== {1'b1, 32'h10, 32'h1111, 5'd1}) begin
        bad++; $display("FAIL bp_hold_%0d got v=%b pc=%h d2=%h exp v=1 pc=10 d2=1111",
                        s, bus.out_valid_o, bus.pc_o, bus.data2_o);
      end
      total++;
    end
    bus.out_ready_i = 1'b1;
    for (int s = 0; s < 2; s++) begin
      #1;
      if (bus.in_ready_o !== 1'b1) begin
        bad++; $display("FAIL b2b_ready_%0d got=%0b exp=1", s, bus.in_ready_o);
      end
      total++;
      tick();
      if ({bus.out_valid_o, bus.pc_o, bus.data2_o} !== {1'b1, 32'h14 + 32'(4*s), 32'h2222 + 32'(s*32'h1111)}) begin
        bad++; $display("FAIL b2b_slot_%0d got v=%b pc=%h d2=%h", s, bus.out_valid_o, bus.pc_o, bus.data2_o);
      end
      total++;
      bus.pc_i = 32'h18; bus.inst_i = i_inst(6'h0C, 5'd0, 5'd3, 16'h3333);
    end
    bus.in_valid_i = 1'b0;
    tick();
  endtask

  task automatic test_flush_stall();
    do_reset();
    regs[2] = 32'h99;
    bus.in_valid_i = 1'b1; bus.pc_i = 32'h20; bus.inst_i = i_inst(6'h0D, 5'd0, 5'd1, 16'h5);
    tick();
    bus.out_ready_i = 1'b0;
    fwd_we = 2'b01; fwd_pend = 2'b01; fwd_addr[0] = 5'd2;
    bus.inst_i = r_inst(5'd2, 5'd2, 5'd4, 5'd0, 6'h25);
    tick();
    if ({bus.out_valid_o, bus.stall_cnt_o} !== {1'b1, 4'd1}) begin
      bad++; $display("FAIL fs_pre got v=%b cnt=%0d exp v=1 cnt=1", bus.out_valid_o, bus.stall_cnt_o);
    end
    total++;
    bus.flush_i = 1'b1;
    #1;
    if (bus.in_ready_o !== 1'b0) begin
      bad++; $display("FAIL fs_ready got=%0b exp=0", bus.in_ready_o);
    end
    total++;
    tick();
    if ({bus.out_valid_o, bus.stall_cnt_o} !== {1'b0, 4'd1}) begin
      bad++; $display("FAIL fs_flush got v=%b cnt=%0d exp v=0 cnt=1", bus.out_valid_o, bus.stall_cnt_o);
    end
    total++;
    bus.flush_i = 1'b0; bus.out_ready_i = 1'b1; clear_fwd();
    tick();
    if ({bus.out_valid_o, bus.data1_o} !== {1'b1, 32'h99}) begin
      bad++; $display("FAIL fs_after got v=%b d1=%h exp v=1 d1=99", bus.out_valid_o, bus.data1_o);
    end
    total++;
    bus.in_valid_i = 1'b0;
    tick();
  endtask

  task automatic test_edges();
    bus.in_valid_i = 1'b1; bus.inst_i = {6'h3F, 26'h0123456};
    tick();
    if ({bus.out_valid_o, bus.illegal_o, bus.we_o, bus.aluop_o, bus.alusel_o, bus.data1_o, bus.data2_o}
        !== {3'b110, EXE_NOP_OP, EXE_RES_NOP, 64'd0}) begin
      bad++; $display("FAIL illegal got v=%b ill=%b we=%b aop=%h d1=%h d2=%h exp v=1 ill=1 we=0 nop zeros",
                      bus.out_valid_o, bus.illegal_o, bus.we_o, bus.aluop_o, bus.data1_o, bus.data2_o);
    end
    total++;
    regs[0] = 32'hDEAD;
    fwd_we = 2'b01; fwd_pend = 2'b01; fwd_addr[0] = 5'd0; fwd_data[0] = 32'h1;
    bus.inst_i = r_inst(5'd0, 5'd0, 5'd7, 5'd0, 6'h25);
    #1;
    if (bus.in_ready_o !== 1'b1) begin
      bad++; $display("FAIL r0_ready got=%0b exp=1", bus.in_ready_o);
    end
    total++;
    tick();
    if ({bus.data1_o, bus.data2_o, bus.illegal_o} !== {64'd0, 1'b0}) begin
      bad++; $display("FAIL r0_data got d1=%h d2=%h ill=%b exp 0 0 0", bus.data1_o, bus.data2_o, bus.illegal_o);
    end
    total++;
    clear_fwd();
    regs[6] = 32'h8000_0001;
    bus.inst_i = r_inst(5'd0, 5'd6, 5'd5, 5'd7, 6'h00);
    tick();
    if ({bus.data1_o, bus.data2_o, bus.waddr_o, bus.aluop_o, bus.alusel_o}
        !== {32'd7, 32'h8000_0001, 5'd5, EXE_SLL_OP, EXE_RES_SHIFT}) begin
      bad++; $display("FAIL sll got d1=%h d2=%h wa=%0d aop=%h sel=%h exp d1=7 d2=80000001 wa=5",
                      bus.data1_o, bus.data2_o, bus.waddr_o, bus.aluop_o, bus.alusel_o);
    end
    total++;
    // Long stall saturates the narrow counter, then reset mid-stall
    do_reset();
    fwd_we = 2'b01; fwd_pend = 2'b01; fwd_addr[0] = 5'd2;
    bus.in_valid_i = 1'b1; bus.inst_i = r_inst(5'd2, 5'd2, 5'd4, 5'd0, 6'h25);
    repeat (20) tick();
    if (bus.stall_cnt_o !== 4'hF) begin
      bad++; $display("FAIL cnt_sat got=%0d exp=15", bus.stall_cnt_o);
    end
    total++;
    rst_n = 1'b0;
    tick();
    if ({bus.stall_cnt_o, bus.out_valid_o} !== {4'd0, 1'b0}) begin
      bad++; $display("FAIL stall_reset got cnt=%0d v=%b exp 0 0", bus.stall_cnt_o, bus.out_valid_o);
    end
    total++;
    rst_n = 1'b1; bus.in_valid_i = 1'b0; clear_fwd();
    tick();
  endtask

  task automatic test_random();
    exp_t        m;
    exp_t        ms;
    logic [31:0] spc;
    logic        sv;
    logic [3:0]  cnt;
    logic        hold;
    logic        hz;
    logic        er;
    do_reset();
    for (int r = 0; r < 32; r++) regs[r] = $urandom;
    ms = '0; spc = 32'd0; sv = 1'b0; cnt = 4'd0; hold = 1'b0;
    for (int it = 0; it < 400; it++) begin
      if (!hold) begin
        bus.inst_i = gen_inst(); bus.pc_i = $urandom;
        bus.in_valid_i = ($urandom_range(0, 3) != 0);
      end
      for (int i = 0; i < 2; i++) begin
        fwd_we[i] = $urandom_range(0, 1); fwd_pend[i] = ($urandom_range(0, 3) == 0);
        fwd_addr[i] = 5'($urandom_range(0, 7)); fwd_data[i] = $urandom;
      end
      bus.out_ready_i = ($urandom_range(0, 9) < 7);
      bus.flush_i = ($urandom_range(0, 15) == 0);
      #1;
      m  = model(bus.inst_i);
      hz = bus.in_valid_i & m.haz;
      er = !bus.flush_i && !hz && (!sv || bus.out_ready_i);
      if ({bus.in_ready_o, bus.re1_o, bus.re2_o, bus.raddr1_o, bus.raddr2_o} !==
          {er, bus.in_valid_i & m.rd1, bus.in_valid_i & m.rd2, bus.inst_i[25:21], bus.inst_i[20:16]}) begin
        bad++; $display("FAIL rnd_in_%0d got rdy=%b re=%b%b exp rdy=%b re=%b%b inst=%h",
                        it, bus.in_ready_o, bus.re1_o, bus.re2_o, er,
                        bus.in_valid_i & m.rd1, bus.in_valid_i & m.rd2, bus.inst_i);
      end
      total++;
      @(posedge clk);
      if (bus.flush_i) sv = 1'b0;
      else if (bus.in_valid_i && er) begin ms = m; spc = bus.pc_i; sv = 1'b1; end
      else if (bus.out_ready_i) sv = 1'b0;
      if (hz && !bus.flush_i && cnt != 4'hF) cnt = cnt + 4'd1;
      hold = bus.in_valid_i && !er;
      #1;
      if ({bus.out_valid_o, bus.stall_cnt_o, bus.we_o, bus.waddr_o, bus.aluop_o, bus.alusel_o,
           bus.data1_o, bus.data2_o, bus.illegal_o, bus.pc_o} !==
          {sv, cnt, ms.we, ms.wa, ms.aop, ms.sel, ms.d1, ms.d2, ms.ill, spc}) begin
        bad++; $display("FAIL rnd_out_%0d got v=%b cnt=%0d we=%b wa=%0d aop=%h d1=%h d2=%h ill=%b exp v=%b cnt=%0d we=%b wa=%0d aop=%h d1=%h d2=%h ill=%b",
                        it, bus.out_valid_o, bus.stall_cnt_o, bus.we_o, bus.waddr_o, bus.aluop_o,
                        bus.data1_o, bus.data2_o, bus.illegal_o,
                        sv, cnt, ms.we, ms.wa, ms.aop, ms.d1, ms.d2, ms.ill);
      end
      total++;
    end
    bus.in_valid_i = 1'b0; bus.flush_i = 1'b0; clear_fwd();
    tick();
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0; total = 0; bad = 0;
    for (int r = 0; r < 32; r++) regs[r] = 32'(r) * 32'h0101_0101;
    bus.inst_i = 32'd0; bus.pc_i = 32'd0;
    bus.flush_i = 1'b0; bus.in_valid_i = 1'b0; bus.out_ready_i = 1'b1;
    clear_fwd();
    test_reset();
    test_ori();
    test_fwd_priority();
    test_load_use();
    test_back_to_back();
    test_flush_stall();
    test_edges();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
